tmr8_apb: RTL

TMR8_APB -- requirements
Module: tmr8_apb

---
 rtl/tmr8_pkg.sv | 25 ++
 rtl/tmr8_prescaler.sv | 37 +++
 rtl/tmr8_apb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tmr8_pkg.sv
// tmr8_pkg: register addresses and TCR/TSR bit positions
// shared by the 8-bit APB timer and its prescaler.
package tmr8_pkg;

  localparam logic [1:0] A_TDR  = 2'd0;
  localparam logic [1:0] A_TCR  = 2'd1;
  localparam logic [1:0] A_TSR  = 2'd2;
  localparam logic [1:0] A_TCNT = 2'd3;

  localparam int TCR_LOAD = 7;
  localparam int TCR_DW   = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_CS1  = 1;
  localparam int TCR_CS0  = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // implemented TCR bits; the rest read back as 0
  localparam logic [7:0] TCR_MASK =
    (8'd1 << TCR_LOAD) | (8'd1 << TCR_DW) |
    (8'd1 << TCR_EN) | (8'd1 << TCR_CS1) |
    (8'd1 << TCR_CS0);

endpackage

// File: rtl/tmr8_prescaler.sv
// tmr8_prescaler: free-running 4-bit divider, cleared while disabled.
// Ports: clk, rst_n, en, clk_sel[1:0] -> tick (1 pclk every 2^(clk_sel+1)).
module tmr8_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] clk_sel,
  output logic       tick
);

  logic [3:0] cnt;
  logic [3:0] mask;

  always_comb begin
    mask = 4'h1;
    unique case (clk_sel)
      2'd0: mask = 4'h1;
      2'd1: mask = 4'h3;
      2'd2: mask = 4'h7;
      2'd3: mask = 4'hF;
    endcase
  end

  // low clk_sel+1 bits all ones marks the last cycle of a period
  assign tick = en & ((cnt & mask) == mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'h0;
    end else if (en) begin
      cnt <= cnt + 4'h1;
    end else begin
      cnt <= 4'h0;
    end
  end

endmodule

// File: rtl/tmr8_apb.sv
// tmr8_apb: 8-bit up/down timer with APB register file
// (TDR, TCR, TSR, TCNT). Ports: APB slave (pclk, presetn, psel,
// penable, pwrite, paddr, pwdata, prdata, pready, pslverr) and
// tmr_ovf / tmr_udf status copies. Define TMR_WAIT_STATE_EN for
// one wait state per transfer.
module tmr8_apb
  import tmr8_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_ovf,
  output logic              tmr_udf
);

  logic [7:0] tdr;
  logic [7:0] tcr;
  logic [1:0] tsr;
  logic [7:0] tcnt;
  logic [1:0] tsr_next;

  logic       access;
  logic       done;
  logic       addr_ok;
  logic       wr;
  logic       rd;
  logic [1:0] reg_sel;

  logic       tick;
  logic       load;
  logic       dw;
  logic       cnt_tick;
  logic       ovf_set;
  logic       udf_set;

  assign access  = psel & penable;
  assign done    = access & pready;
  assign addr_ok = (paddr >> 2) == '0;
  assign reg_sel = paddr[1:0];
  assign wr      = done & pwrite & addr_ok;
  assign rd      = done & ~pwrite & addr_ok;
  assign pslverr = done & ~addr_ok;

`ifdef TMR_WAIT_STATE_EN
  logic ws;

  // first access cycle stalls, second completes
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ws <= 1'b0;
    end else begin
      ws <= access & ~ws;
    end
  end

  assign pready = ws;
`else
  assign pready = 1'b1;
`endif

  always_comb begin
    prdata = 8'h00;
    if (rd) begin
      unique case (reg_sel)
        A_TDR:  prdata = tdr;
        A_TCR:  prdata = tcr;
        A_TSR:  prdata = {6'b0, tsr};
        A_TCNT: prdata = tcnt;
      endcase
    end
  end

  tmr8_prescaler u_presc (
    .clk     (pclk),
    .rst_n   (presetn),
    .en      (tcr[TCR_EN]),
    .clk_sel (tcr[TCR_CS1:TCR_CS0]),
    .tick    (tick)
  );

  assign load     = tcr[TCR_LOAD];
  assign dw       = tcr[TCR_DW];
  assign cnt_tick = tick & ~load;
  assign ovf_set  = cnt_tick & ~dw & (tcnt == 8'hFF);
  assign udf_set  = cnt_tick & dw & (tcnt == 8'h00);

  // hardware set is ORed after the software clear so it wins
  always_comb begin
    tsr_next = tsr;
    if (wr && reg_sel == A_TSR) begin
      tsr_next = tsr & pwdata[1:0];
    end
    tsr_next[TSR_OVF] = tsr_next[TSR_OVF] | ovf_set;
    tsr_next[TSR_UDF] = tsr_next[TSR_UDF] | udf_set;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr  <= 8'h00;
      tcr  <= 8'h00;
      tsr  <= 2'b00;
      tcnt <= 8'h00;
    end else begin
      if (wr && reg_sel == A_TDR) begin
        tdr <= pwdata;
      end
      if (wr && reg_sel == A_TCR) begin
        tcr <= pwdata & TCR_MASK;
      end
      tsr <= tsr_next;
      if (load) begin
        tcnt <= tdr;
      end else if (cnt_tick) begin
        tcnt <= dw ? tcnt - 8'd1 : tcnt + 8'd1;
      end
    end
  end

  assign tmr_ovf = tsr[TSR_OVF];
  assign tmr_udf = tsr[TSR_UDF];

endmodule
